// File: rtl/imem_pkg.sv
// Shared constants and helpers for the synchronous instruction memory.
package imem_pkg;
   localparam logic [31:0] NOP_DEFAULT    = 32'h00000013;  // addi x0,x0,0
   localparam int          FAULT_MISALIGN = 0;
   localparam int          FAULT_RANGE    = 1;

   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction
endpackage

// File: rtl/imem_ram.sv
// DEPTH x 32 storage: byte-strobed write port, registered read with read enable.
module imem_ram
   import imem_pkg::*;
#(
   parameter int DEPTH = 512,
   parameter int AW    = addr_w(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic [3:0]    wstrb_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);
   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   // Read data is held while re_i is low, which keeps a stalled response stable.
   always_ff @(posedge clk_i) begin
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/imem_sync.sv
// Instruction memory with valid/ready fetch port, loader write port, flush,
// fault flags and a consumed-response counter.
module imem_sync
   import imem_pkg::*;
#(
   parameter int          DEPTH     = 512,
   parameter logic [31:0] NOP_INSTR = NOP_DEFAULT,
   parameter int          CNT_W     = 32,
   localparam int         AW        = addr_w(DEPTH)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [31:0]      req_addr_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [31:0]      rsp_instr_o,
   output logic [1:0]       rsp_fault_o,
   input  logic             flush_i,
   input  logic             prog_we_i,
   input  logic [AW-1:0]    prog_addr_i,
   input  logic [31:0]      prog_wdata_i,
   input  logic [3:0]       prog_wstrb_i,
   output logic [CNT_W-1:0] fetch_count_o
);
   logic             rsp_valid_q, rsp_valid_d;
   logic [1:0]       fault_q, fault_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept, consume;
   logic [31:0]      rdata;

   assign req_ready_o = !prog_we_i && !flush_i && (!rsp_valid_q || rsp_ready_i);
   assign accept      = req_valid_i && req_ready_o;
   assign consume     = rsp_valid_q && rsp_ready_i && !flush_i;

   always_comb begin
      fault_d                 = fault_q;
      rsp_valid_d             = rsp_valid_q;
      cnt_d                   = cnt_q + CNT_W'(consume);
      if (accept) begin
         fault_d[FAULT_MISALIGN] = |req_addr_i[1:0];
         fault_d[FAULT_RANGE]    = |req_addr_i[31:AW+2];
      end
      if (flush_i)          rsp_valid_d = 1'b0;
      else if (accept)      rsp_valid_d = 1'b1;
      else if (rsp_ready_i) rsp_valid_d = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rsp_valid_q <= 1'b0;
         fault_q     <= '0;
         cnt_q       <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         fault_q     <= fault_d;
         cnt_q       <= cnt_d;
      end
   end

   // Faulted fetches never touch the array; the NOP is substituted on output.
   imem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk_i   (clk_i),
      .we_i    (prog_we_i),
      .waddr_i (prog_addr_i),
      .wdata_i (prog_wdata_i),
      .wstrb_i (prog_wstrb_i),
      .re_i    (accept && !(|req_addr_i[1:0]) && !(|req_addr_i[31:AW+2])),
      .raddr_i (req_addr_i[AW+1:2]),
      .rdata_o (rdata)
   );

   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_fault_o   = fault_q;
   assign rsp_instr_o   = !rsp_valid_q ? 32'h0 : ((|fault_q) ? NOP_INSTR : rdata);
   assign fetch_count_o = cnt_q;
endmodule
